// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: single-purchase vending transaction controller.
// Latches a one-hot item selection and gates the coin mechanism while collecting.
// Accumulates nickel/dime credit in one shared register and pulses dispense.
// Returns change or refunds one nickel at a time (one cycle high, one cycle low).
module vend_txn_ctrl #(
  parameter int unsigned PRICE0   = 15,
  parameter int unsigned PRICE1   = 25,
  parameter int unsigned PRICE2   = 30,
  parameter int unsigned PRICE3   = 35,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [3:0]          item_sel,
  input  logic                select_valid,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                cancel,
  output logic                coin_enable,
  output logic                dispense,
  output logic                nickel_out,
  output logic                busy,
  output logic                select_error,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          item_id
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHG_PULSE,
    S_CHG_GAP
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [TIMER_W-1:0]  timer;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] next_credit;
  logic                coin_seen;
  logic                timed_out;
  logic                sel_onehot;
  logic [1:0]          sel_index;

  // Decode the front-panel request into a validity flag and an item index.
  always_comb begin
    sel_onehot = 1'b1;
    sel_index  = 2'd0;
    case (item_sel)
      4'b0001: sel_index = 2'd0;
      4'b0010: sel_index = 2'd1;
      4'b0100: sel_index = 2'd2;
      4'b1000: sel_index = 2'd3;
      default: sel_onehot = 1'b0;
    endcase
  end

  // Price of the latched item; item_id only changes on an accepted select.
  always_comb begin
    price = CREDIT_W'(PRICE0);
    case (item_id)
      2'd0: price = CREDIT_W'(PRICE0);
      2'd1: price = CREDIT_W'(PRICE1);
      2'd2: price = CREDIT_W'(PRICE2);
      2'd3: price = CREDIT_W'(PRICE3);
      default: price = CREDIT_W'(PRICE0);
    endcase
  end

  // Credit after this cycle's coins; a nickel and a dime together add 15.
  always_comb begin
    coin_seen   = nickel_in | dime_in;
    next_credit = credit
                + (nickel_in ? CREDIT_W'(5)  : CREDIT_W'(0))
                + (dime_in   ? CREDIT_W'(10) : CREDIT_W'(0));
    timed_out   = !coin_seen && (timer == TIMER_W'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; cancel outranks timeout, which outranks reaching the price.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    case (state)
      S_IDLE: begin
        if (select_valid && sel_onehot) next_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (cancel || timed_out)
          next_state = (next_credit != '0) ? S_CHG_PULSE : S_IDLE;
        else if (next_credit >= price)
          next_state = S_VEND;
      end
      S_VEND:      next_state = (credit > price) ? S_CHG_PULSE : S_IDLE;
      S_CHG_PULSE: next_state = S_CHG_GAP;
      S_CHG_GAP:   next_state = (credit == '0) ? S_IDLE : S_CHG_PULSE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    coin_enable = (state == S_COLLECT);
    dispense    = (state == S_VEND);
    nickel_out  = (state == S_CHG_PULSE);
    busy        = (state != S_IDLE);
  end

  // Shared credit datapath, coin-idle timer, latched item and select error flag.
  always_ff @(posedge clock) begin
    // NOTE: the datapath takes the same synchronous reset as the FSM, so a
    // reset mid-transaction drops credit without paying any change.
    if (!reset_n) begin
      credit       <= '0;
      timer        <= '0;
      item_id      <= 2'd0;
      select_error <= 1'b0;
    end else begin
      select_error <= (state == S_IDLE) && select_valid && !sel_onehot;
      case (state)
        S_IDLE: begin
          if (select_valid && sel_onehot) begin
            item_id <= sel_index;
            credit  <= '0;
            timer   <= '0;
          end
        end
        S_COLLECT: begin
          credit <= next_credit;
          timer  <= coin_seen ? '0 : timer + TIMER_W'(1);
        end
        S_VEND:      credit <= credit - price;
        S_CHG_PULSE: credit <= credit - CREDIT_W'(5);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb_vend_txn_ctrl: directed scenarios plus randomized purchases for vend_txn_ctrl.
// The random section predicts each transaction from the pricing rules with
// plain arithmetic: running credit, coin-free cycle count, refund/change counts.
module tb_vend_txn_ctrl;

  localparam int TO = 8;
  localparam int CW = 6;

  logic          clock;
  logic          reset_n;
  logic [3:0]    item_sel;
  logic          select_valid;
  logic          nickel_in;
  logic          dime_in;
  logic          cancel;
  logic          coin_enable;
  logic          dispense;
  logic          nickel_out;
  logic          busy;
  logic          select_error;
  logic [CW-1:0] credit;
  logic [1:0]    item_id;

  int checks = 0;
  int errors = 0;

  vend_txn_ctrl #(
    .PRICE0(15), .PRICE1(25), .PRICE2(30), .PRICE3(35),
    .TIMEOUT(TO), .CREDIT_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .item_sel(item_sel),
    .select_valid(select_valid), .nickel_in(nickel_in), .dime_in(dime_in),
    .cancel(cancel), .coin_enable(coin_enable), .dispense(dispense),
    .nickel_out(nickel_out), .busy(busy), .select_error(select_error),
    .credit(credit), .item_id(item_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int price_of(input int idx);
    case (idx)
      0: return 15;
      1: return 25;
      2: return 30;
      default: return 35;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it, inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs();
    item_sel     = 4'b0000;
    select_valid = 1'b0;
    nickel_in    = 1'b0;
    dime_in      = 1'b0;
    cancel       = 1'b0;
  endtask

  task automatic select(input logic [3:0] sel);
    item_sel     = sel;
    select_valid = 1'b1;
    tick();
    quiet_inputs();
  endtask

  task automatic coin(input logic n, input logic d);
    nickel_in = n;
    dime_in   = d;
    tick();
    quiet_inputs();
  endtask

  // Expect `pulses` nickels, one high / one low each, then IDLE. Coins and
  // cancel are toggled randomly throughout since they must be ignored here.
  task automatic payout(input int pulses);
    for (int i = 0; i < pulses; i++) begin
      check("pay_pulse_hi", 32'(nickel_out), 1);
      check("pay_no_disp", 32'(dispense), 0);
      check("pay_credit_hi", 32'(credit), 32'((pulses - i) * 5));
      nickel_in = 1'($urandom_range(0, 1));
      dime_in   = 1'($urandom_range(0, 1));
      cancel    = 1'($urandom_range(0, 1));
      tick();
      check("pay_pulse_lo", 32'(nickel_out), 0);
      check("pay_busy_gap", 32'(busy), 1);
      check("pay_credit_lo", 32'(credit), 32'((pulses - i - 1) * 5));
      tick();
    end
    quiet_inputs();
    check("pay_idle_busy", 32'(busy), 0);
    check("pay_idle_nick", 32'(nickel_out), 0);
    check("pay_idle_credit", 32'(credit), 0);
  endtask

  initial begin
    int  idx;
    int  price;
    int  mcredit;
    int  idle;
    bit  n;
    bit  d;
    bit  cn;
    bit  done;

    // Reset state.
    reset_n = 1'b0;
    quiet_inputs();
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_credit", 32'(credit), 0);
    check("rst_item", 32'(item_id), 0);
    check("rst_coin_en", 32'(coin_enable), 0);
    check("rst_disp", 32'(dispense), 0);
    check("rst_nick", 32'(nickel_out), 0);
    check("rst_selerr", 32'(select_error), 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 0);

    // Exact pay on item 0: dime then nickel reaches 15.
    select(4'b0001);
    check("ex_busy", 32'(busy), 1);
    check("ex_coin_en", 32'(coin_enable), 1);
    check("ex_item", 32'(item_id), 0);
    check("ex_credit0", 32'(credit), 0);
    coin(1'b0, 1'b1);
    check("ex_credit10", 32'(credit), 10);
    check("ex_no_disp", 32'(dispense), 0);
    coin(1'b1, 1'b0);
    check("ex_credit15", 32'(credit), 15);
    check("ex_disp", 32'(dispense), 1);
    check("ex_coin_off", 32'(coin_enable), 0);
    check("ex_no_nick", 32'(nickel_out), 0);
    tick();
    check("ex_idle_busy", 32'(busy), 0);
    check("ex_idle_disp", 32'(dispense), 0);
    check("ex_idle_nick", 32'(nickel_out), 0);
    check("ex_idle_credit", 32'(credit), 0);

    // Overpay on item 3: four dimes = 40 for a 35 item, one nickel back.
    select(4'b1000);
    check("op_item", 32'(item_id), 3);
    repeat (3) coin(1'b0, 1'b1);
    check("op_credit30", 32'(credit), 30);
    check("op_no_disp", 32'(dispense), 0);
    coin(1'b0, 1'b1);
    check("op_credit40", 32'(credit), 40);
    check("op_disp", 32'(dispense), 1);
    tick();
    check("op_disp_once", 32'(dispense), 0);
    payout(1);

    // Cancel on item 1 with nickel+dime in the same cycle: refund three nickels.
    select(4'b0010);
    check("cn_item", 32'(item_id), 1);
    nickel_in = 1'b1;
    dime_in   = 1'b1;
    cancel    = 1'b1;
    tick();
    quiet_inputs();
    check("cn_no_disp", 32'(dispense), 0);
    payout(3);

    // Timeout with credit 5 on item 2.
    select(4'b0100);
    check("to_item", 32'(item_id), 2);
    coin(1'b1, 1'b0);
    check("to_credit5", 32'(credit), 5);
    repeat (TO - 1) tick();
    check("to_still_collect", 32'(coin_enable), 1);
    tick();
    check("to_no_disp", 32'(dispense), 0);
    payout(1);

    // Timeout with zero credit: straight back to IDLE.
    select(4'b0100);
    repeat (TO - 1) tick();
    check("to0_still_collect", 32'(coin_enable), 1);
    tick();
    payout(0);

    // Bad select: not one-hot, then a dime that must not be credited.
    item_sel     = 4'b0110;
    select_valid = 1'b1;
    tick();
    quiet_inputs();
    check("bad_selerr", 32'(select_error), 1);
    check("bad_busy", 32'(busy), 0);
    check("bad_coin_en", 32'(coin_enable), 0);
    coin(1'b0, 1'b1);
    check("bad_selerr_pulse", 32'(select_error), 0);
    check("bad_no_credit", 32'(credit), 0);
    check("bad_still_idle", 32'(busy), 0);
    item_sel     = 4'b0000;
    select_valid = 1'b1;
    tick();
    quiet_inputs();
    check("zero_selerr", 32'(select_error), 1);
    check("zero_busy", 32'(busy), 0);

    // Reset held two cycles mid-COLLECT with credit 10.
    select(4'b1000);
    coin(1'b0, 1'b1);
    check("mr_credit10", 32'(credit), 10);
    reset_n = 1'b0;
    tick();
    tick();
    check("mr_busy", 32'(busy), 0);
    check("mr_credit", 32'(credit), 0);
    check("mr_item", 32'(item_id), 0);
    check("mr_nick", 32'(nickel_out), 0);
    check("mr_disp", 32'(dispense), 0);
    reset_n = 1'b1;
    tick();
    check("mr_after_busy", 32'(busy), 0);
    check("mr_after_nick", 32'(nickel_out), 0);
    check("mr_after_credit", 32'(credit), 0);

    // Randomized purchases against an arithmetic model of each transaction.
    for (int t = 0; t < 60; t++) begin
      idx   = $urandom_range(0, 3);
      price = price_of(idx);
      select(4'(1 << idx));
      check("rnd_item", 32'(item_id), 32'(idx));
      check("rnd_busy", 32'(busy), 1);
      mcredit = 0;
      idle    = 1;
      done    = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        n  = ($urandom_range(0, 2) == 0);
        d  = ($urandom_range(0, 2) == 0);
        cn = ($urandom_range(0, 24) == 0);
        nickel_in    = n;
        dime_in      = d;
        cancel       = cn;
        select_valid = ($urandom_range(0, 5) == 0);
        item_sel     = 4'($urandom);
        mcredit = mcredit + (n ? 5 : 0) + (d ? 10 : 0);
        tick();
        quiet_inputs();
        if (cn || (!n && !d && idle == TO)) begin
          check("rnd_refund_no_disp", 32'(dispense), 0);
          payout(mcredit / 5);
          done = 1'b1;
        end else if (mcredit >= price) begin
          check("rnd_disp", 32'(dispense), 1);
          check("rnd_disp_credit", 32'(credit), 32'(mcredit));
          tick();
          check("rnd_disp_once", 32'(dispense), 0);
          payout((mcredit - price) / 5);
          done = 1'b1;
        end else begin
          check("rnd_collect", 32'(coin_enable), 1);
          check("rnd_credit", 32'(credit), 32'(mcredit));
          idle = (n || d) ? 1 : idle + 1;
        end
      end
      check("rnd_done", 32'(done), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
